serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 121 ++++++++++++
 tb/tb_serial_adder.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: processes BPC bits per clock, LSB slice first,
// and publishes the full result, carry and signed overflow on completion.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / BPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] acc_next;
    logic             carry_reg;
    logic [WIDTH-1:0] s_reg;
    logic             cout_reg;
    logic             ovf_reg;

    logic [BPC-1:0]   a_slice;
    logic [BPC-1:0]   b_slice;
    logic [BPC-1:0]   sum_slice;
    logic [BPC:0]     c;
    logic             last;
    int unsigned      base;

    assign base    = 32'(cnt_reg) * 32'(BPC);
    assign a_slice = a_reg[base +: BPC];
    assign b_slice = b_reg[base +: BPC];
    assign last    = (cnt_reg == CW'(N - 1));

    // Ripple through the slice; c[BPC-1] is the carry into the operand MSB on the final slice.
    assign c[0] = carry_reg;
    for (genvar gi = 0; gi < BPC; gi++) begin : g_fa
        assign sum_slice[gi] = a_slice[gi] ^ b_slice[gi] ^ c[gi];
        assign c[gi+1]       = (a_slice[gi] & b_slice[gi]) |
                               (a_slice[gi] & c[gi]) |
                               (b_slice[gi] & c[gi]);
    end

    always_comb begin
        acc_next              = acc_reg;
        acc_next[base +: BPC] = sum_slice;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            carry_reg <= 1'b0;
            s_reg     <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    // Subtraction is a + ~b + 1, with the borrow-in folded into the carry.
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b ^ {WIDTH{sub}};
                        carry_reg <= cin ^ sub;
                        cnt_reg   <= '0;
                        acc_reg   <= '0;
                    end
                end
                RUN: begin
                    carry_reg <= c[BPC];
                    acc_reg   <= acc_next;
                    cnt_reg   <= last ? '0 : cnt_reg + CW'(1);
                    if (last) begin
                        s_reg    <= acc_next;
                        cout_reg <= c[BPC];
                        ovf_reg  <= c[BPC] ^ c[BPC-1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready = (state_reg == IDLE);
    assign done  = (state_reg == DONE);
    assign s     = s_reg;
    assign cout  = cout_reg;
    assign ovf   = ovf_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at BPC = 1, 4 and 8 (WIDTH = 8).
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] a, b;
    logic       cin, sub;
    logic       start_v [3];
    logic       ready_v [3];
    logic       done_v  [3];
    logic       cout_v  [3];
    logic       ovf_v   [3];
    logic [7:0] s_v     [3];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] s;
        logic       cout;
        logic       ovf;
        int         lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .BPC(1)) dut_b1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a), .b(b), .cin(cin), .sub(sub),
        .ready(ready_v[0]), .done(done_v[0]), .s(s_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]));

    serial_adder #(.WIDTH(8), .BPC(4)) dut_b4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a), .b(b), .cin(cin), .sub(sub),
        .ready(ready_v[1]), .done(done_v[1]), .s(s_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1]));

    serial_adder #(.WIDTH(8), .BPC(8)) dut_b8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a), .b(b), .cin(cin), .sub(sub),
        .ready(ready_v[2]), .done(done_v[2]), .s(s_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, expv);
        end
    endtask

    // Called at a negedge; drives start immediately so acceptance is the next rising edge.
    task automatic run_op(input int sel, input logic [7:0] ta, input logic [7:0] tb2,
                          input logic tcin, input logic tsub, input logic hold);
        exp_t       e;
        logic [7:0] bb;
        logic [8:0] full;
        logic [7:0] s_prev;
        int         edges;
        bb     = tsub ? ~tb2 : tb2;
        full   = {1'b0, ta} + {1'b0, bb} + {8'd0, tcin ^ tsub};
        e.s    = full[7:0];
        e.cout = full[8];
        e.ovf  = (ta[7] == bb[7]) && (full[7] != ta[7]);
        e.lat  = (sel == 0) ? 9 : (sel == 1) ? 3 : 2;
        sb.push_back(e);
        s_prev = s_v[sel];

        a = ta; b = tb2; cin = tcin; sub = tsub; start_v[sel] = 1'b1;
        @(negedge clk);
        edges = 1;
        if (!hold) start_v[sel] = 1'b0;
        a = ~ta; b = ~tb2; cin = ~tcin; sub = ~tsub;
        while (!done_v[sel] && edges < 40) begin
            chk("s_stable_in_run", s_v[sel], s_prev);
            @(negedge clk);
            edges++;
        end
        start_v[sel] = 1'b0;
        e = sb.pop_front();
        chk("done_seen", done_v[sel], 1);
        chk("latency", edges, e.lat);
        chk("s", s_v[sel], e.s);
        chk("cout", cout_v[sel], e.cout);
        chk("ovf", ovf_v[sel], e.ovf);
        $display("op dut=%0d a=%02h b=%02h cin=%0d sub=%0d hold=%0d -> s=%02h cout=%0d ovf=%0d edges=%0d",
                 sel, ta, tb2, tcin, tsub, hold, s_v[sel], cout_v[sel], ovf_v[sel], edges);
        @(negedge clk);
        chk("done_one_cycle", done_v[sel], 0);
        chk("ready_after", ready_v[sel], 1);
        chk("s_held", s_v[sel], e.s);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_ready", ready_v[i], 1);
            chk("rst_done", done_v[i], 0);
            chk("rst_s", s_v[i], 0);
            chk("rst_cout", cout_v[i], 0);
            chk("rst_ovf", ovf_v[i], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        chk("ready_release", ready_v[0], 1);

        run_op(0, 8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);
        run_op(0, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
        run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
        run_op(0, 8'h05, 8'h07, 1'b0, 1'b1, 1'b0);
        run_op(0, 8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
        run_op(0, 8'h3C, 8'h11, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++)
            run_op(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);

        // Abort an operation in its 4th RUN cycle.
        a = 8'h33; b = 8'h44; cin = 1'b0; sub = 1'b0; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_s", s_v[0], 0);
        chk("abort_ready", ready_v[0], 1);
        chk("abort_done", done_v[0], 0);
        chk("abort_cout", cout_v[0], 0);
        chk("abort_ovf", ovf_v[0], 0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_hold_done", done_v[0], 0);
        end
        rst_n = 1'b1;
        run_op(0, 8'h12, 8'h34, 1'b1, 1'b0, 1'b0);

        run_op(1, 8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0);
        run_op(1, 8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
        run_op(2, 8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0);
        run_op(2, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_op(1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            run_op(2, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
